// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calc_sequencer slice: datapath widths, the
// sequencer state type, opcode name constants and the multi-cycle helper.
// No ports (package).
// ---------------------------------------------------------------------------
package calc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned SEL_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [OPC_W-1:0] OPC_ADD  = 4'd0;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'd1;
  localparam logic [OPC_W-1:0] OPC_AND  = 4'd2;
  localparam logic [OPC_W-1:0] OPC_OR   = 4'd3;
  localparam logic [OPC_W-1:0] OPC_MUL  = 4'd4;
  localparam logic [OPC_W-1:0] OPC_DIV  = 4'd5;
  localparam logic [OPC_W-1:0] OPC_XOR  = 4'd6;
  localparam logic [OPC_W-1:0] OPC_NOT  = 4'd7;
  localparam logic [OPC_W-1:0] OPC_SHL  = 4'd8;
  localparam logic [OPC_W-1:0] OPC_SHR  = 4'd9;
  localparam logic [OPC_W-1:0] OPC_ROL  = 4'd10;
  localparam logic [OPC_W-1:0] OPC_ROR  = 4'd11;
  localparam logic [OPC_W-1:0] OPC_MIN  = 4'd12;
  localparam logic [OPC_W-1:0] OPC_MAX  = 4'd13;
  localparam logic [OPC_W-1:0] OPC_CMP  = 4'd14;
  localparam logic [OPC_W-1:0] OPC_PASS = 4'd15;

  // An opcode dwells in WAIT only if its mask bit is set and there is
  // actually something to wait for.
  function automatic logic op_is_multi(input logic [SEL_W-1:0] mask,
                                       input logic [OPC_W-1:0] opc,
                                       input int unsigned      wait_cycles);
    return mask[opc] && (wait_cycles != 0);
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// ---------------------------------------------------------------------------
// calc_sequencer_if
// Bundles the command handshake, the result handshake and the arithmetic
// unit / result multiplexer signals of calc_sequencer.
//   slave  : sequencer side (calc_sequencer)
//   master : environment side (command source, mux, result consumer)
// ---------------------------------------------------------------------------
interface calc_sequencer_if;
  import calc_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPC_W-1:0]  cmd_opcode;
  logic [DATA_W-1:0] cmd_operand;
  logic [SEL_W-1:0]  hotselect;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] muxout;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_operand, muxout, res_ready,
    output cmd_ready, hotselect, operand_b, acc, res_valid, res_data, busy
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_operand, muxout, res_ready,
    input  cmd_ready, hotselect, operand_b, acc, res_valid, res_data, busy
  );

endinterface

// File: rtl/calc_sequencer_opcode_onehot_decoder.sv
// ---------------------------------------------------------------------------
// opcode_onehot_decoder
// Turns the latched opcode into the one-hot select for the downstream
// 16-input result multiplexer. Output is all-zero while en is low.
//   en      : in  1      decoder enable
//   opcode  : in  OPC_W  operation select
//   onehot  : out SEL_W  one-hot select (or zero)
// ---------------------------------------------------------------------------
module opcode_onehot_decoder
  import calc_pkg::*;
(
  input  logic             en,
  input  logic [OPC_W-1:0] opcode,
  output logic [SEL_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[opcode] = 1'b1;
  end

endmodule

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Accepts one command at a time, drives a one-hot select to the external
// result multiplexer for one cycle (or 1+WAIT_CYCLES cycles for opcodes
// flagged in MULTI_MASK), captures the mux output into the accumulator and
// presents it as a result until the consumer accepts it.
//   clk   : in  single clock, rising edge
//   rst_n : in  asynchronous active-low reset
//   bus   : calc_sequencer_if.slave (cmd_*, res_*, hotselect, operand_b,
//           acc, muxout, busy)
// ---------------------------------------------------------------------------
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned      WAIT_CYCLES = 4,
  parameter logic [SEL_W-1:0] MULTI_MASK  = 16'h0030
) (
  input  logic              clk,
  input  logic              rst_n,
  calc_sequencer_if.slave   bus
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [OPC_W-1:0]  opcode_q;
  logic [DATA_W-1:0] operand_b_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic accept;
  logic multi;
  logic capture;
  logic sel_en;

  assign multi = op_is_multi(MULTI_MASK, opcode_q, WAIT_CYCLES);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and control decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    sel_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = bus.cmd_valid;
        if (bus.cmd_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        sel_en = 1'b1;
        if (multi) begin
          state_d = ST_WAIT;
        end else begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        sel_en = 1'b1;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, dwell counter and accumulator capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= '0;
      operand_b_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        opcode_q    <= bus.cmd_opcode;
        operand_b_q <= bus.cmd_operand;
      end
      // EXEC counts as the first select cycle, so WAIT needs WAIT_CYCLES-1
      // further decrements to reach zero on its last cycle.
      if (state_q == ST_EXEC && multi) cnt_q <= CNT_W'(WAIT_CYCLES - 1);
      else if (state_q == ST_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (capture) acc_q <= bus.muxout;
    end
  end

  opcode_onehot_decoder u_dec (
    .en     (sel_en),
    .opcode (opcode_q),
    .onehot (bus.hotselect)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.res_valid = (state_q == ST_RESP);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.operand_b = operand_b_q;
  assign bus.acc       = acc_q;
  assign bus.res_data  = acc_q;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  localparam int unsigned TB_WAIT = 4;
  localparam logic [15:0] TB_MASK = 16'h0030;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  calc_sequencer_if bus();

  calc_sequencer #(
    .WAIT_CYCLES (TB_WAIT),
    .MULTI_MASK  (TB_MASK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: number of cycles the select is driven for an opcode.
  function automatic int model_latency(input logic [3:0] opc);
    logic [15:0] m;
    m = TB_MASK;
    return (m[opc] && TB_WAIT > 0) ? 1 + int'(TB_WAIT) : 1;
  endfunction

  // Issue one command and follow it to completion. The mux output in the
  // k-th select cycle is base + k*step; the result must be the value seen
  // in the final select cycle. hold = extra RESP cycles with res_ready low.
  task automatic run_op(input logic [3:0] opc, input logic [31:0] opnd,
                        input logic [31:0] base, input logic [31:0] step,
                        input int hold);
    int          lat;
    logic [31:0] expv;
    logic [15:0] exph;
    lat  = model_latency(opc);
    exph = 16'h0001 << opc;
    expv = base + 32'(lat - 1) * step;
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = opc;
    bus.cmd_operand = opnd;
    bus.res_ready   = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = 4'($urandom);
    bus.cmd_operand = $urandom;
    for (int k = 0; k < lat; k++) begin
      bus.muxout    = base + 32'(k) * step;
      bus.cmd_valid = 1'($urandom);
      bus.res_ready = 1'($urandom);
      chk("hotselect", 32'(bus.hotselect), 32'(exph));
      chk("onehot", 32'($onehot(bus.hotselect)), 32'd1);
      chk("sel_ready", 32'(bus.cmd_ready), 32'd0);
      chk("sel_valid", 32'(bus.res_valid), 32'd0);
      chk("operand_b", bus.operand_b, opnd);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      bus.muxout = $urandom;
      chk("resp_valid", 32'(bus.res_valid), 32'd1);
      chk("resp_data", bus.res_data, expv);
      chk("resp_acc", bus.acc, expv);
      chk("resp_hot", 32'(bus.hotselect), 32'd0);
      chk("resp_ready", 32'(bus.cmd_ready), 32'd0);
      chk("resp_busy", 32'(bus.busy), 32'd1);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("done_valid", 32'(bus.res_valid), 32'd0);
    chk("done_ready", 32'(bus.cmd_ready), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_acc", bus.acc, expv);
  endtask

  initial begin
    int          accs[$];
    logic [15:0] hots[$];
    int          n;

    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = '0;
    bus.cmd_operand = '0;
    bus.muxout      = '0;
    bus.res_ready   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", bus.acc, 32'd0);
    chk("rst_opb", bus.operand_b, 32'd0);
    chk("rst_hot", 32'(bus.hotselect), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    // res_ready while no result pending does nothing
    bus.res_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_rr_valid", 32'(bus.res_valid), 32'd0);
      chk("idle_rr_busy", 32'(bus.busy), 32'd0);
    end
    bus.res_ready = 1'b0;

    // Directed: single-cycle opcode 2, multi-cycle opcode 4
    run_op(4'd2, 32'd5, 32'h0000_0007, 32'd0, 0);
    run_op(4'd4, $urandom, 32'hDEAD_BEEF, 32'd0, 0);
    // Capture must use the value of the final select cycle
    run_op(4'd5, $urandom, 32'h1000_0000, 32'h0000_0101, 1);
    // Long stall in RESP with cmd_valid high
    run_op(4'd9, $urandom, $urandom, 32'd3, 10);

    // Back-to-back with cmd_valid and res_ready held high
    @(posedge clk); #1;
    n = 0;
    bus.res_ready  = 1'b1;
    bus.cmd_opcode = 4'd0;
    bus.cmd_valid  = 1'b1;
    bus.muxout     = 32'h55;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (n == 2) bus.cmd_valid = 1'b0;
      if (bus.hotselect != 16'h0) hots.push_back(bus.hotselect);
      if (bus.cmd_valid && bus.cmd_ready) begin
        accs.push_back(cyc);
        bus.cmd_opcode = (n == 0) ? 4'd0 : 4'd15;
        n++;
      end
    end
    bus.res_ready = 1'b0;
    chk("b2b_accepts", 32'(accs.size()), 32'd2);
    chk("b2b_spacing", 32'((accs.size() > 1) ? accs[1] - accs[0] : -1), 32'd3);
    chk("b2b_hot_cnt", 32'(hots.size()), 32'd2);
    chk("b2b_hot0", 32'((hots.size() > 0) ? hots[0] : 16'hFFFF), 32'h0001);
    chk("b2b_hot1", 32'((hots.size() > 1) ? hots[1] : 16'hFFFF), 32'h8000);
    @(posedge clk); #1;
    chk("b2b_idle", 32'(bus.cmd_ready), 32'd1);

    // Reset pulsed during WAIT of opcode 5
    run_op(4'd1, $urandom, 32'hA5A5_0001, 32'd0, 0);
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = 4'd5;
    bus.cmd_operand = 32'h1234_5678;
    bus.muxout      = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_hot", 32'(bus.hotselect), 32'h0020);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", bus.acc, 32'd0);
    chk("mid_rst_hot", 32'(bus.hotselect), 32'd0);
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_opb", bus.operand_b, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_valid", 32'(bus.res_valid), 32'd0);
      chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
      chk("abort_acc", bus.acc, 32'd0);
    end

    // Sweep every opcode with random data
    for (int o = 0; o < 16; o++) begin
      run_op(4'(o), $urandom, $urandom, 32'($urandom_range(0, 255)),
             int'($urandom_range(0, 2)));
    end

    // Random commands
    for (int r = 0; r < 12; r++) begin
      run_op(4'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
